mac_accum_ctrl: RTL and testbench

- Sequential front end of the MAC unit: accepts operand pairs over a valid/ready handshake and registers their unsigned product.
- Accumulates NUM_TAPS products into an ACC_W-bit running sum through the team's 24-bit adder stage.
- Presents the finished sum downstream with a valid/ready handshake, then clears for the next block of taps.

---
 rtl/mac_pkg.sv | 14 +
 rtl/nbit_hw_adder.sv | 12 +
 rtl/mac_accum_ctrl.sv | 137 +++++++++++++
 tb/tb_mac_accum_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared widths and FSM encoding for the MAC accumulate front end.
package mac_pkg;

    localparam int unsigned MAC_DATA_W = 12;
    localparam int unsigned MAC_ACC_W  = 24;

    // Encodings are fixed: ACCUM=0, FLUSH=1, OUTPUT=2.
    typedef enum logic [1:0] {
        StAccum  = 2'd0,
        StFlush  = 2'd1,
        StOutput = 2'd2
    } mac_state_e;

endpackage

// File: rtl/nbit_hw_adder.sv
// Plain nbit-wide adder stage; carry out is not exported.
module nbit_hw_adder #(
    parameter int unsigned nbit = 24
) (
    input  logic [nbit-1:0] a,
    input  logic [nbit-1:0] b,
    output logic [nbit-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/mac_accum_ctrl.sv
// MAC front end: registers operand products, accumulates NUM_TAPS of them and
// hands the sum downstream over a valid/ready handshake.
module mac_accum_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W   = MAC_DATA_W,
    parameter int unsigned ACC_W    = MAC_ACC_W,
    parameter int unsigned NUM_TAPS = 8,
    parameter int unsigned CNT_W    = $clog2(NUM_TAPS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] TapCnt  = CNT_W'(NUM_TAPS);
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_TAPS - 1);

    mac_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] prod_q, prod_d;
    logic             prod_v_q, prod_v_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic             accept;
    logic             last_tap;

    // in_ready depends only on local state and clear, never on out_ready.
    assign in_ready = (state_q == StAccum) && (cnt_q < TapCnt) && !clear;
    assign accept   = in_valid && in_ready;
    assign last_tap = accept && (cnt_q == LastIdx);

    nbit_hw_adder #(
        .nbit (ACC_W)
    ) u_adder (
        .a   (acc_q),
        .b   (prod_q),
        .sum (sum)
    );

    // Wrapped sum smaller than the old accumulator means a carry out was lost.
    assign carry = (sum < acc_q);

    // Next-state: tap capture, accumulation, FSM and handshake, clear last.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        prod_d      = prod_q;
        prod_v_d    = 1'b0;
        out_valid_d = out_valid_q;

        if (accept) begin
            prod_d   = ACC_W'(in_a) * ACC_W'(in_b);
            prod_v_d = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
        end

        if (prod_v_q) begin
            acc_d = sum;
            ovf_d = ovf_q | carry;
        end

        unique case (state_q)
            StAccum: begin
                if (last_tap) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                state_d = StOutput;
            end
            StOutput: begin
                // out_valid is registered, so it rises one edge after entry.
                if (out_valid_q && out_ready) begin
                    state_d     = StAccum;
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StAccum;
            end
        endcase

        if (clear) begin
            state_d     = StAccum;
            cnt_d       = '0;
            acc_d       = '0;
            ovf_d       = 1'b0;
            prod_v_d    = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAccum;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_accum_ctrl.sv
// Directed bench for mac_accum_ctrl with NUM_TAPS=4 and a result scoreboard.
module tb_mac_accum_ctrl;

    localparam int unsigned DATA_W   = 12;
    localparam int unsigned ACC_W    = 24;
    localparam int unsigned NUM_TAPS = 4;

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic             ovf;
    } result_t;

    typedef logic [DATA_W-1:0] tap_arr_t [NUM_TAPS];

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              clear     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] in_a      = '0;
    logic [DATA_W-1:0] in_b      = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ovf;
    logic [ACC_W-1:0]  out_acc;

    result_t           sb_q[$];
    logic [ACC_W-1:0]  m_acc = '0;
    logic              m_ovf = 1'b0;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    mac_accum_ctrl #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .NUM_TAPS (NUM_TAPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference accumulation using an explicit 25-bit carry.
    task automatic model_tap(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [ACC_W-1:0] p;
        logic [ACC_W:0]   s;
        p     = ACC_W'(a) * ACC_W'(b);
        s     = {1'b0, m_acc} + {1'b0, p};
        m_ovf = m_ovf | s[ACC_W];
        m_acc = s[ACC_W-1:0];
    endtask

    // Presents one operand pair; returns 1ns after the accepting edge.
    task automatic send_tap(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        #1;
        check("tap_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic feed(input tap_arr_t as, input tap_arr_t bs, input bit gap);
        result_t r;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (gap && i > 0) begin
                @(posedge clk);
                #1;
                check("bubble_in_ready", in_ready, 1);
            end
            send_tap(as[i], bs[i]);
            model_tap(as[i], bs[i]);
        end
        r.acc = m_acc;
        r.ovf = m_ovf;
        sb_q.push_back(r);
        m_acc = '0;
        m_ovf = 1'b0;
    endtask

    // Waits (bounded) for out_valid, pops the scoreboard and checks the result.
    task automatic expect_result(input string tag, input int hold);
        int      n;
        result_t exp_r;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 10) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, n, 2);
        exp_r = sb_q.pop_front();
        check({tag, "_acc"}, out_acc, exp_r.acc);
        check({tag, "_ovf"}, out_ovf, exp_r.ovf);
        check({tag, "_in_ready_busy"}, in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            check({tag, "_held_valid"}, out_valid, 1);
            check({tag, "_held_acc"}, out_acc, exp_r.acc);
            check({tag, "_held_in_ready"}, in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_in_ready_back"}, in_ready, 1);
        check({tag, "_acc_cleared"}, out_acc, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tap_arr_t ta;
        tap_arr_t tbv;

        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_acc", out_acc, 0);
        check("rst_out_ovf", out_ovf, 0);
        #11;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // Basic sum
        ta  = '{12'd1, 12'd3, 12'd5, 12'd7};
        tbv = '{12'd2, 12'd4, 12'd6, 12'd8};
        feed(ta, tbv, 1'b0);
        expect_result("basic", 0);

        // Overflow then a clean block
        ta  = '{12'd4095, 12'd4095, 12'd4095, 12'd4095};
        tbv = '{12'd4095, 12'd4095, 12'd4095, 12'd4095};
        feed(ta, tbv, 1'b0);
        expect_result("ovf", 0);
        ta  = '{12'd1, 12'd1, 12'd1, 12'd1};
        tbv = '{12'd1, 12'd1, 12'd1, 12'd1};
        feed(ta, tbv, 1'b0);
        expect_result("after_ovf", 0);

        // Backpressure for 5 cycles
        out_ready = 1'b0;
        ta  = '{12'd1, 12'd3, 12'd5, 12'd7};
        tbv = '{12'd2, 12'd4, 12'd6, 12'd8};
        feed(ta, tbv, 1'b0);
        expect_result("bp", 5);

        // Input bubbles
        feed(ta, tbv, 1'b1);
        expect_result("bubble", 0);

        // Clear mid-block with a competing in_valid
        send_tap(12'd10, 12'd10);
        send_tap(12'd20, 12'd20);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_a     = 12'd9;
        in_b     = 12'd9;
        #1;
        check("clear_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("clear_acc", out_acc, 0);
        check("clear_ovf", out_ovf, 0);
        check("clear_valid", out_valid, 0);
        ta  = '{12'd2, 12'd2, 12'd2, 12'd2};
        tbv = '{12'd2, 12'd2, 12'd2, 12'd2};
        feed(ta, tbv, 1'b0);
        expect_result("post_clear", 0);

        // Async reset mid-block
        for (int i = 0; i < 3; i++) begin
            send_tap(12'd4095, 12'd4095);
            model_tap(12'd4095, 12'd4095);
        end
        @(posedge clk);
        #2;
        check("pre_rst_acc", out_acc, m_acc);
        check("pre_rst_ovf", out_ovf, m_ovf);
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_acc", out_acc, 0);
        check("arst_ovf", out_ovf, 0);
        #10;
        rst_n = 1'b1;
        m_acc = '0;
        m_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_result", out_valid, 0);
        end
        check("arst_in_ready", in_ready, 1);
        ta  = '{12'd1, 12'd3, 12'd5, 12'd7};
        tbv = '{12'd2, 12'd4, 12'd6, 12'd8};
        feed(ta, tbv, 1'b0);
        expect_result("post_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
